timer_bank: RTL

//  Parametrised multi-channel down-counting timer peripheral on the CPU bridge bus.

---
 rtl/timer_bank_pkg.sv | 24 ++
 rtl/timer_bank_channel.sv | 117 +++++++++++
 rtl/timer_bank.sv | 77 +++++++
 3 files changed

// File: rtl/timer_bank_pkg.sv
// Shared constants for the timer_bank peripheral: register offsets, modes, FSM states, CTRL bits.
// Optional feature macro: TIMER_BANK_PRESCALE_EN (adds CTRL[11:4] PSC prescaler).
package timer_bank_pkg;

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPreset = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    localparam logic [1:0] ModeOneshot = 2'd0;
    localparam logic [1:0] ModeReload  = 2'd1;

    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlImBit   = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StFire = 2'd3
    } tb_state_e;

endpackage

// File: rtl/timer_bank_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT/STATUS registers and its FSM.
// With TIMER_BANK_PRESCALE_EN defined, CTRL[11:4] sets a per-channel prescale divider.
module timer_bank_channel
    import timer_bank_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we_ctrl,
    input  logic        i_we_preset,
    input  logic        i_we_status,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ctrl,
    output logic [31:0] o_preset,
    output logic [31:0] o_count,
    output logic [31:0] o_status,
    output logic        o_irq
);

    tb_state_e            r_state;
    logic                 r_en;
    logic [1:0]           r_mode;
    logic                 r_im;
    logic                 r_pend;
    logic [CNT_WIDTH-1:0] r_preset;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_tick;
    logic                 w_unused_wdata;
    logic [7:0]           w_psc_rd;

`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0] r_psc;
    logic [7:0] r_pcnt;
    assign w_tick   = (r_pcnt == r_psc);
    assign w_psc_rd = r_psc;
`else
    assign w_tick   = 1'b1;
    assign w_psc_rd = 8'd0;
`endif

    assign w_unused_wdata = ^i_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_en     <= 1'b0;
            r_mode   <= ModeOneshot;
            r_im     <= 1'b0;
            r_pend   <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
`ifdef TIMER_BANK_PRESCALE_EN
            r_psc    <= 8'd0;
            r_pcnt   <= 8'd0;
`endif
        end else begin
            if (i_we_preset) r_preset <= i_wdata[CNT_WIDTH-1:0];
            if (i_we_status && i_wdata[0]) r_pend <= 1'b0;
            if (i_we_ctrl) begin
                r_en   <= i_wdata[CtrlEnBit];
                r_mode <= i_wdata[CtrlModeLsb +: 2];
                r_im   <= i_wdata[CtrlImBit];
`ifdef TIMER_BANK_PRESCALE_EN
                r_psc  <= i_wdata[11:4];
`endif
            end
            unique case (r_state)
                StIdle: if (r_en) r_state <= StLoad;
                StLoad: begin
                    r_count <= r_preset;
`ifdef TIMER_BANK_PRESCALE_EN
                    r_pcnt  <= 8'd0;
`endif
                    r_state <= StCnt;
                end
                StCnt: begin
                    if (!r_en) begin
                        r_state <= StIdle;
                    end else begin
`ifdef TIMER_BANK_PRESCALE_EN
                        r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
`endif
                        if (w_tick) begin
                            if (r_count > CNT_WIDTH'(1)) begin
                                r_count <= r_count - CNT_WIDTH'(1);
                            end else begin
                                r_count <= '0;
                                r_state <= StFire;
                            end
                        end
                    end
                end
                StFire: begin
                    // Set is issued after the W1C clear above so it wins in the same cycle.
                    r_pend <= 1'b1;
                    if (i_we_ctrl && !i_wdata[CtrlEnBit]) begin
                        r_state <= StIdle;
                    end else if (r_mode == ModeReload) begin
                        r_state <= StLoad;
                    end else begin
                        r_state <= StIdle;
                        if (!i_we_ctrl) r_en <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ctrl   = {20'd0, w_psc_rd, r_im, r_mode, r_en};
    assign o_preset = 32'(r_preset);
    assign o_count  = 32'(r_count);
    assign o_status = {31'd0, r_pend};
    assign o_irq    = r_pend & r_im;

endmodule

// File: rtl/timer_bank.sv
// NUM_CH-channel timer bank: address decode, channel instances, read mux and IRQ vector.
// Optional feature macro: TIMER_BANK_PRESCALE_EN (per-channel prescaler in CTRL[11:4]).
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_WIDTH = 32,
    localparam int unsigned AddrW    = $clog2(NUM_CH) + 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [AddrW-1:0]  i_addr,
    input  logic              i_we,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic [NUM_CH-1:0] o_irq,
    output logic              o_irq_any
);

    logic [3:0]  w_ch;
    logic [1:0]  w_reg;
    logic        w_ch_ok;
    logic        w_unused_addr;
    logic [31:0] w_ctrl   [NUM_CH];
    logic [31:0] w_preset [NUM_CH];
    logic [31:0] w_count  [NUM_CH];
    logic [31:0] w_status [NUM_CH];

    if (AddrW > 4) begin : g_ch_dec
        assign w_ch = 4'(i_addr[AddrW-1:4]);
    end else begin : g_ch_single
        assign w_ch = 4'd0;
    end

    assign w_reg         = i_addr[3:2];
    assign w_ch_ok       = (32'(w_ch) < NUM_CH);
    assign w_unused_addr = ^i_addr[1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic w_sel;
        assign w_sel = i_we && w_ch_ok && (32'(w_ch) == g);

        timer_bank_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_chan (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_we_ctrl   (w_sel && (w_reg == RegCtrl)),
            .i_we_preset (w_sel && (w_reg == RegPreset)),
            .i_we_status (w_sel && (w_reg == RegStatus)),
            .i_wdata     (i_wdata),
            .o_ctrl      (w_ctrl[g]),
            .o_preset    (w_preset[g]),
            .o_count     (w_count[g]),
            .o_status    (w_status[g]),
            .o_irq       (o_irq[g])
        );
    end

    always_comb begin
        o_rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_ch_ok && (32'(w_ch) == i)) begin
                unique case (w_reg)
                    RegCtrl:   o_rdata = w_ctrl[i];
                    RegPreset: o_rdata = w_preset[i];
                    RegCount:  o_rdata = w_count[i];
                    RegStatus: o_rdata = w_status[i];
                    default:   o_rdata = '0;
                endcase
            end
        end
    end

    assign o_irq_any = |o_irq;

endmodule
